sd_cmd_engine: RTL

SPI-mode SD command/response engine, the parametrised successor of the fixed single-shot command+R1 sequencer. It issues one 48-bit command frame with internally generated CRC7 and captures an R1 (8-bit) or R3/R7 (40-bit) response, selected per command. It also applies a configurable response timeout and retries automatically on timeout or a card-reported CRC error. It sits between the SD init/read controllers and the SPI pins, with one SPI bit per `clk`.

---
 rtl/sd_cmd_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// SPI-mode SD command engine: sends one 48-bit CMD frame with CRC7, captures R1 or R3/R7, retries on timeout/CRC error.
// isStart is a level request; isFinish holds in DONE until isStart drops.
module sd_cmd_engine #(
  parameter int PRE_CYCLES  = 8,
  parameter int TIMEOUT     = 100,
  parameter int MAX_RETRY   = 3,
  parameter int TAIL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  index,
  input  logic [31:0] argument,
  input  logic        resp_long,
  input  logic        isStart,
  output logic        isBusy,
  output logic        isFinish,
  output logic        DI,
  input  logic        DO,
  output logic [39:0] response,
  output logic [1:0]  error,
  output logic [2:0]  attempts
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SEND, S_WAIT, S_CAPT, S_TAIL, S_DONE} state_t;

  localparam logic [11:0] PRE_LAST  = 12'(PRE_CYCLES - 1);
  localparam logic [11:0] TO_LAST   = 12'(TIMEOUT - 1);
  localparam logic [11:0] TAIL_LAST = 12'(TAIL_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        long_q, long_d;
  logic [38:0] sh_q, sh_d;
  logic [39:0] response_q, response_d;
  logic [1:0]  error_q, error_d;
  logic [2:0]  attempts_q, attempts_d;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  logic [39:0] head;
  logic [47:0] frame;
  logic [5:0]  bit_sel;
  logic [39:0] captured;
  logic [7:0]  r1;
  logic [11:0] cap_last;
  logic        fail;
  logic [1:0]  fail_code;

  assign head     = {2'b01, idx_q, arg_q};
  assign frame    = {head, crc7(head), 1'b1};
  assign bit_sel  = 6'd47 - cnt_q[5:0];
  assign captured = {sh_q, DO};
  // The R1 byte leads every response, so for R3/R7 it is the top byte.
  assign r1       = long_q ? captured[39:32] : captured[7:0];
  assign cap_last = long_q ? 12'd39 : 12'd7;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    long_d     = long_q;
    sh_d       = sh_q;
    response_d = response_q;
    error_d    = error_q;
    attempts_d = attempts_q;
    fail       = 1'b0;
    fail_code  = 2'd0;
    case (state_q)
      S_IDLE: if (isStart) begin
        idx_d      = index;
        arg_d      = argument;
        long_d     = resp_long;
        response_d = '1;
        error_d    = 2'd0;
        attempts_d = 3'd0;
        cnt_d      = '0;
        state_d    = S_PRE;
      end
      S_PRE: if (cnt_q == PRE_LAST) begin
        cnt_d   = '0;
        state_d = S_SEND;
      end else cnt_d = cnt_q + 12'd1;
      S_SEND: if (cnt_q == 12'd47) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end else cnt_d = cnt_q + 12'd1;
      S_WAIT: if (!DO) begin
        sh_d    = captured[38:0];
        cnt_d   = 12'd1;
        state_d = S_CAPT;
      end else if (cnt_q == TO_LAST) begin
        fail       = 1'b1;
        fail_code  = 2'd1;
        response_d = '1;
      end else cnt_d = cnt_q + 12'd1;
      S_CAPT: begin
        sh_d = captured[38:0];
        if (cnt_q == cap_last) begin
          response_d = long_q ? captured : {32'hFFFF_FFFF, captured[7:0]};
          if (r1[2]) begin
            error_d = 2'd3;
            cnt_d   = '0;
            state_d = S_TAIL;
          end else if (r1[3]) begin
            fail      = 1'b1;
            fail_code = 2'd2;
          end else begin
            cnt_d   = '0;
            state_d = S_TAIL;
          end
        end else cnt_d = cnt_q + 12'd1;
      end
      S_TAIL: if (cnt_q == TAIL_LAST) begin
        cnt_d   = '0;
        state_d = S_DONE;
      end else cnt_d = cnt_q + 12'd1;
      S_DONE: if (!isStart) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      cnt_d = '0;
      if (attempts_q < RETRY_MAX) begin
        attempts_d = attempts_q + 3'd1;
        state_d    = S_PRE;
      end else begin
        error_d = fail_code;
        state_d = S_TAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      arg_q      <= '0;
      long_q     <= 1'b0;
      sh_q       <= '1;
      response_q <= '1;
      error_q    <= 2'd0;
      attempts_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      long_q     <= long_d;
      sh_q       <= sh_d;
      response_q <= response_d;
      error_q    <= error_d;
      attempts_q <= attempts_d;
    end
  end

  assign isBusy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign isFinish = (state_q == S_DONE);
  assign DI       = (state_q == S_SEND) ? frame[bit_sel] : 1'b1;
  assign response = response_q;
  assign error    = error_q;
  assign attempts = attempts_q;

endmodule
